cnt_dly_pipe: RTL and testbench
===============================

// Module: cnt_dly_pipe
// PURPOSE
//  Parametrised up/down counter with a DEPTH-stage registered delay line of its value.
//  Generalises the single counter + one-cycle-delayed copy: adds width/depth params,
//  enable, load, direction, wrap/limit flag and a delayed-value valid qualifier.
//  Used as a stimulus/timing source and as a known-latency reference in block-level benches.
// PARAMETERS
//  WIDTH    4   counter and delay-line data width, >=1
//  DEPTH    1   delay-line stages, >=1 (DEPTH=1: dly_o is cnt_o one cycle late)
//  RST_VAL  0   counter reset value, WIDTH bits
// PORTS
//  clk       in   1      single clock, all state on posedge
//  rstn      in   1      synchronous reset, active-low
//  en        in   1      count enable
//  load      in   1      load load_val into counter
//  load_val  in   WIDTH  value to load
//  dir       in   1      dir_e: DIR_UP=0 increment, DIR_DOWN=1 decrement
//  cnt_o     out  WIDTH  current counter value (registered)
//  wrap_o    out  1      one-cycle pulse: last update crossed/hit the limit
//  dly_o     out  WIDTH  cnt_o delayed by exactly DEPTH cycles
//  dly_vld   out  1      dly_o holds a post-reset value
// BEHAVIOUR
//  - Interface: one clock clk; reset rstn synchronous, active-low.
//  - Reset (rstn=0 at posedge): cnt_o=RST_VAL, wrap_o=0, all delay stages=0, dly_vld=0.
//    Reset mid-operation behaves identically; no state survives.
//  - Counter update per posedge, rstn=1, priority order:
//    1. load=1: cnt_o<=load_val, wrap_o<=0 (load wins over en, dir ignored)
//    2. en=1, dir=UP:   cnt_o<=cnt_o+1 mod 2^WIDTH
//    3. en=1, dir=DOWN: cnt_o<=cnt_o-1 mod 2^WIDTH
//    4. else hold, wrap_o<=0
//  - wrap_o: registered; =1 in the cycle cnt_o shows the post-limit value, i.e. after
//    UP from 2^WIDTH-1 or DOWN from 0; otherwise 0. Never set by load.
//  - Delay line: shifts every posedge regardless of en/load; stage0<=cnt_o,
//    stage k<=stage k-1; dly_o=stage DEPTH-1. dly_o(t)=cnt_o(t-DEPTH).
//  - dly_vld: valid bit shifts alongside data, injected as 1 after reset release;
//    first 1 exactly DEPTH cycles after the first non-reset posedge, then stays 1.
//  - Latency: en/load -> cnt_o 1 cycle; cnt_o -> dly_o DEPTH cycles.
//  - All arithmetic unsigned WIDTH bits; no X on any output after first reset edge.
// CONFIGURATION
//  CNT_SATURATE_EN defined: counter saturates instead of wrapping: UP at 2^WIDTH-1
//   holds 2^WIDTH-1, DOWN at 0 holds 0; wrap_o pulses 1 cycle for each enabled step
//   attempted at the limit (value unchanged). Load unaffected.
//  CNT_SATURATE_EN undefined: modular wrap as above.
// STRUCTURE
//  - cnt_pkg: typedef enum logic {DIR_UP=1'b0, DIR_DOWN=1'b1} dir_e; shared with benches.
//  - Sub-module dly_line #(WIDTH,DEPTH): data+valid shift register with clk/rstn;
//    counter logic stays in cnt_dly_pipe.
// TESTING
//  1. Reset 2 cycles, release, en=1 UP, WIDTH=4 DEPTH=1: cnt_o 0,1,2..15,0; wrap_o=1
//     exactly in the cycle cnt_o=0; dly_o trails cnt_o by 1; dly_vld=1 from cycle 1.
//  2. DEPTH=3, en=1 UP: dly_o=cnt_o-3 every cycle; dly_vld low first 3 cycles, then 1.
//  3. cnt_o=5, load=1 load_val=12 en=1 dir=UP same cycle -> cnt_o=12, wrap_o=0.
//  4. load 0, en=1 DOWN -> cnt_o 15, wrap_o=1; with CNT_SATURATE_EN -> cnt_o 0, wrap_o=1.
//  5. Counting at cnt_o=9, assert rstn=0 one cycle -> next cycle cnt_o=RST_VAL,
//     dly_o=0, dly_vld=0, wrap_o=0; refill resumes after release.
//  6. en=0 10 cycles at cnt_o=7 -> cnt_o holds 7, dly_o settles to 7, wrap_o=0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared definitions for the counter/delay-line block and its benches.
package cnt_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/dly_line.sv
// DEPTH-stage registered delay line carrying a data word plus a valid bit.
// The valid bit is injected as 1 on every non-reset edge, so it marks post-reset data.
module dly_line #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);

    logic [WIDTH-1:0] tap  [DEPTH+1];
    logic             vtap [DEPTH+1];

    assign tap[0]  = din;
    assign vtap[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] data_reg;
            logic             vld_reg;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    data_reg <= '0;
                    vld_reg  <= 1'b0;
                end else begin
                    data_reg <= tap[gi];
                    vld_reg  <= vtap[gi];
                end
            end

            assign tap[gi+1]  = data_reg;
            assign vtap[gi+1] = vld_reg;
        end
    endgenerate

    assign dout = tap[DEPTH];
    assign vld  = vtap[DEPTH];

endmodule

// File: rtl/cnt_dly_pipe.sv
// Up/down counter with load, limit flag and a DEPTH-cycle delayed copy of its value.
// Define CNT_SATURATE_EN to make the counter stick at its limits instead of wrapping.
module cnt_dly_pipe
    import cnt_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  dir_e             dir,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] dly_o,
    output logic             dly_vld
);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             wrap_reg, wrap_next;
    logic             at_limit;

    // Limit depends on direction: all-ones going up, zero going down.
    assign at_limit = (dir == DIR_UP) ? (cnt_reg == {WIDTH{1'b1}}) : (cnt_reg == '0);

    always_comb begin
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        if (load) begin
            cnt_next = load_val;
        end else if (en) begin
            wrap_next = at_limit;
`ifdef CNT_SATURATE_EN
            if (!at_limit) begin
                cnt_next = (dir == DIR_UP) ? cnt_reg + WIDTH'(1) : cnt_reg - WIDTH'(1);
            end
`else
            cnt_next = (dir == DIR_UP) ? cnt_reg + WIDTH'(1) : cnt_reg - WIDTH'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg  <= RST_VAL;
            wrap_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            wrap_reg <= wrap_next;
        end
    end

    assign cnt_o  = cnt_reg;
    assign wrap_o = wrap_reg;

    dly_line #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dly_line (
        .clk  (clk),
        .rstn (rstn),
        .din  (cnt_reg),
        .dout (dly_o),
        .vld  (dly_vld)
    );

endmodule

// File: tb/tb_cnt_dly_pipe.sv
// Self-checking bench: two instances (DEPTH=1 and DEPTH=3) driven in lockstep,
// compared each cycle against a cycle-history reference model.
module tb_cnt_dly_pipe;
    import cnt_pkg::*;

    localparam int         W    = 4;
    localparam int         D0   = 1;
    localparam int         D1   = 3;
    localparam logic [3:0] RV0  = 4'd0;
    localparam logic [3:0] RV1  = 4'd5;
    localparam int         MAXV = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rstn, en, load;
    logic [3:0] load_val;
    dir_e       dir;

    logic [3:0] cnt0, dly0, cnt1, dly1;
    logic       wrap0, vld0, wrap1, vld1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_dly_pipe #(.WIDTH(W), .DEPTH(D0), .RST_VAL(RV0)) u_d1 (
        .clk(clk), .rstn(rstn), .en(en), .load(load), .load_val(load_val), .dir(dir),
        .cnt_o(cnt0), .wrap_o(wrap0), .dly_o(dly0), .dly_vld(vld0)
    );

    cnt_dly_pipe #(.WIDTH(W), .DEPTH(D1), .RST_VAL(RV1)) u_d3 (
        .clk(clk), .rstn(rstn), .en(en), .load(load), .load_val(load_val), .dir(dir),
        .cnt_o(cnt1), .wrap_o(wrap1), .dly_o(dly1), .dly_vld(vld1)
    );

    // Reference model: integer counter value plus full history of values by cycle.
    int m_cnt  [2];
    bit m_wrap [2];
    int hist0 [$];
    int hist1 [$];
    int cyc     = 0;
    int rst_idx = 0;
    bit started = 1'b0;

    function automatic void model_count(int i);
        int v;
        v = m_cnt[i];
        if (!rstn) begin
            m_cnt[i]  = (i == 0) ? int'(RV0) : int'(RV1);
            m_wrap[i] = 1'b0;
        end else if (load) begin
            m_cnt[i]  = int'(load_val);
            m_wrap[i] = 1'b0;
        end else if (en) begin
            if (dir == DIR_UP) begin
                m_wrap[i] = (v == MAXV);
`ifdef CNT_SATURATE_EN
                m_cnt[i] = (v == MAXV) ? MAXV : v + 1;
`else
                m_cnt[i] = (v + 1) % (MAXV + 1);
`endif
            end else begin
                m_wrap[i] = (v == 0);
`ifdef CNT_SATURATE_EN
                m_cnt[i] = (v == 0) ? 0 : v - 1;
`else
                m_cnt[i] = (v + MAXV) % (MAXV + 1);
`endif
            end
        end else begin
            m_wrap[i] = 1'b0;
        end
    endfunction

    task automatic chk(string tag, int obs, int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(bit r, bit e, bit l, logic [3:0] lv, dir_e d);
        int exp_d0, exp_d1;
        bit exp_v0, exp_v1;
        rstn = r; en = e; load = l; load_val = lv; dir = d;
        @(posedge clk);
        cyc++;
        model_count(0);
        model_count(1);
        hist0.push_back(m_cnt[0]);
        hist1.push_back(m_cnt[1]);
        if (!r) begin
            rst_idx = cyc;
            started = 1'b1;
        end
        exp_v0 = (cyc - D0 >= rst_idx);
        exp_v1 = (cyc - D1 >= rst_idx);
        exp_d0 = exp_v0 ? hist0[cyc - D0] : 0;
        exp_d1 = exp_v1 ? hist1[cyc - D1] : 0;
        #1;
        if (started) begin
            chk("cnt_d1",  int'(cnt0),  m_cnt[0]);
            chk("wrap_d1", int'(wrap0), int'(m_wrap[0]));
            chk("dly_d1",  int'(dly0),  exp_d0);
            chk("vld_d1",  int'(vld0),  int'(exp_v0));
            chk("cnt_d3",  int'(cnt1),  m_cnt[1]);
            chk("wrap_d3", int'(wrap1), int'(m_wrap[1]));
            chk("dly_d3",  int'(dly1),  exp_d1);
            chk("vld_d3",  int'(vld1),  int'(exp_v1));
            $display("cyc=%0d rstn=%0b en=%0b load=%0b lv=%0d dir=%0d | d1 cnt=%0d wrap=%0b dly=%0d vld=%0b | d3 cnt=%0d wrap=%0b dly=%0d vld=%0b",
                     cyc, r, e, l, lv, d, cnt0, wrap0, dly0, vld0, cnt1, wrap1, dly1, vld1);
        end
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_wrap[0] = 1'b0; m_wrap[1] = 1'b0;
        hist0.push_back(0);
        hist1.push_back(0);
        rstn = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; dir = DIR_UP;

        // Reset two cycles, then count up across the wrap point.
        step(0, 0, 0, 4'd0, DIR_UP);
        step(0, 0, 0, 4'd0, DIR_UP);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 4'd0, DIR_UP);

        // Load 5, then load 12 with en/UP in the same cycle: load wins.
        step(1, 0, 1, 4'd5, DIR_UP);
        step(1, 1, 1, 4'd12, DIR_UP);
        chk("load_wins", int'(cnt0), 12);

        // Load 0 then step down through the lower limit.
        step(1, 0, 1, 4'd0, DIR_DOWN);
        step(1, 1, 0, 4'd0, DIR_DOWN);
`ifdef CNT_SATURATE_EN
        chk("down_limit", int'(cnt0), 0);
`else
        chk("down_limit", int'(cnt0), 15);
`endif
        chk("down_wrap", int'(wrap0), 1);
        step(1, 1, 0, 4'd0, DIR_DOWN);

        // Count to 9 then reset mid-operation for one cycle.
        step(1, 0, 1, 4'd6, DIR_UP);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 4'd0, DIR_UP);
        chk("pre_reset", int'(cnt0), 9);
        step(0, 1, 0, 4'd0, DIR_UP);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 4'd0, DIR_UP);

        // Hold at 7 with en low.
        step(1, 0, 1, 4'd7, DIR_UP);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 4'd0, DIR_DOWN);
        chk("hold_dly", int'(dly1), 7);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 dir_e'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
